// File: rtl/nlz_arb_pkg.sv
// Shared types for the NLZ32 sharing arbiter: ID tag and the two pipeline stage records.
package nlz_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W      = 32;
    localparam int ID_W_MAX    = 3;

    // Sized for the largest supported requester count (8); narrower configs use the low bits.
    typedef logic [ID_W_MAX-1:0] id_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        id_t               id;
    } s1_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] num;
        logic       zero;
        id_t        id;
    } s2_t;

endpackage

// File: rtl/NLZ32.sv
// 32-bit leading-zero counter; O_Valid low means the operand was all-zero (O_Num is then 0).
module NLZ32 (
    input  logic [31:0] I_Data,
    output logic [4:0]  O_Num,
    output logic        O_Valid
);

    logic found;

    always_comb begin
        O_Num = '0;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!found && I_Data[i]) begin
                O_Num = 5'(31 - i);
                found = 1'b1;
            end
        end
        O_Valid = found;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer, pointer moves past the winner on update.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               update,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_any
);

    logic [ID_W-1:0] ptr;
    logic [ID_W:0]   cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_any && req[cand[ID_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[ID_W-1:0];
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= '0;
        end else if (update && grant_any) begin
            ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end
    end

endmodule

// File: rtl/nlz_share_arbiter.sv
// Shares one NLZ32 between NUM_REQ requesters: round-robin grant, operand stage (S1),
// result stage (S2) tagged with the requester ID, consumer backpressure via I_Rdy.
module nlz_share_arbiter
    import nlz_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        I_Req,
    input  logic [NUM_REQ*DATA_W-1:0] I_Data,
    output logic [NUM_REQ-1:0]        O_Ack,
    output logic                      O_Valid,
    output logic [4:0]                O_Num,
    output logic                      O_Zero,
    output logic [ID_W-1:0]           O_ID,
    input  logic                      I_Rdy
);

    s1_t s1;
    s2_t s2;

    logic               adv1;
    logic               adv2;
    logic               take;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;
    logic [DATA_W-1:0]  sel_data;
    logic [4:0]         nlz_num;
    logic               nlz_vld;
    logic               unused_id_bits;

    assign adv2 = !s2.valid || I_Rdy;
    assign adv1 = !s1.valid || adv2;
    // Reset cycles never grant, so no ack is lost to the clearing registers.
    assign take = adv1 && !reset;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clock     (clock),
        .reset     (reset),
        .req       (I_Req),
        .update    (take),
        .grant     (gnt),
        .grant_idx (gnt_idx),
        .grant_any (gnt_any)
    );

    assign O_Ack = take ? gnt : '0;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                sel_data = I_Data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1 <= '0;
        end else if (adv1) begin
            s1.valid <= gnt_any;
            if (gnt_any) begin
                s1.data <= sel_data;
                s1.id   <= id_t'(gnt_idx);
            end
        end
    end

    NLZ32 u_nlz (
        .I_Data  (s1.data),
        .O_Num   (nlz_num),
        .O_Valid (nlz_vld)
    );

    // Payload only loads with a real operand so idle outputs stay at their last result.
    always_ff @(posedge clock) begin
        if (reset) begin
            s2 <= '0;
        end else if (adv2) begin
            s2.valid <= s1.valid;
            if (s1.valid) begin
                s2.num  <= nlz_num;
                s2.zero <= !nlz_vld;
                s2.id   <= s1.id;
            end
        end
    end

    assign O_Valid        = s2.valid;
    assign O_Num          = s2.num;
    assign O_Zero         = s2.zero;
    assign O_ID           = s2.id[ID_W-1:0];
    assign unused_id_bits = ^s2.id;

endmodule

// File: tb/tb_nlz_share_arbiter.sv
// Self-checking bench for nlz_share_arbiter: directed scenarios plus random traffic
// against a queue-based model (2-slot capacity, 2-cycle minimum latency, round-robin search).
module tb_nlz_share_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic            clock  = 1'b0;
    logic            reset  = 1'b1;
    logic [N-1:0]    I_Req  = '0;
    logic [N*32-1:0] I_Data = '0;
    logic            I_Rdy  = 1'b1;
    logic [N-1:0]    O_Ack;
    logic            O_Valid;
    logic [4:0]      O_Num;
    logic            O_Zero;
    logic [IW-1:0]   O_ID;

    always #5 clock = ~clock;

    nlz_share_arbiter #(.NUM_REQ(N)) dut (
        .clock   (clock),
        .reset   (reset),
        .I_Req   (I_Req),
        .I_Data  (I_Data),
        .O_Ack   (O_Ack),
        .O_Valid (O_Valid),
        .O_Num   (O_Num),
        .O_Zero  (O_Zero),
        .O_ID    (O_ID),
        .I_Rdy   (I_Rdy)
    );

    typedef struct {
        int          acc;
        logic [31:0] data;
        int          id;
    } item_t;

    item_t         q_m[$];
    int            ptr_m   = 0;
    int            cyc     = 0;
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [N-1:0]  exp_ack;
    logic          exp_valid;
    logic [4:0]    exp_num;
    logic          exp_zero;
    logic [IW-1:0] exp_id;
    int            exp_g;

    function automatic void golden(input logic [31:0] d, output logic [4:0] n, output logic z);
        logic [31:0] v;
        int          cnt;
        v   = d;
        cnt = 0;
        z   = (d == 32'h0);
        if (!z) begin
            while (!v[31]) begin
                v = v << 1;
                cnt++;
            end
        end
        n = 5'(cnt);
    endfunction

    function automatic logic [31:0] rand_data();
        logic [31:0] d;
        d = $urandom;
        return d >> $urandom_range(0, 32);
    endfunction

    // Expected outputs for the current cycle from model state and the driven inputs.
    task automatic predict();
        int idx;
        exp_g   = -1;
        exp_ack = '0;
        if (!reset && (q_m.size() < 2 || I_Rdy)) begin
            for (int k = 0; k < N; k++) begin
                idx = (ptr_m + k) % N;
                if (exp_g < 0 && I_Req[idx]) exp_g = idx;
            end
        end
        if (exp_g >= 0) exp_ack[exp_g] = 1'b1;
        exp_valid = (q_m.size() > 0) && (q_m[0].acc + 2 <= cyc);
        exp_num   = '0;
        exp_zero  = 1'b0;
        exp_id    = '0;
        if (exp_valid) begin
            golden(q_m[0].data, exp_num, exp_zero);
            exp_id = IW'(q_m[0].id);
        end
    endtask

    task automatic commit();
        item_t it;
        if (reset) begin
            q_m.delete();
            ptr_m = 0;
        end else begin
            if (exp_valid && I_Rdy) void'(q_m.pop_front());
            if (exp_g >= 0) begin
                it.acc  = cyc;
                it.data = I_Data[exp_g*32 +: 32];
                it.id   = exp_g;
                q_m.push_back(it);
                ptr_m = (exp_g + 1) % N;
            end
        end
        cyc++;
    endtask

    task automatic sample();
        @(negedge clock);
        predict();
    endtask

    task automatic tick();
        @(posedge clock);
        commit();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) begin
            sample();
            tick();
        end
        reset = 1'b0;
    endtask

    task automatic refresh_reqs(input logic [N-1:0] acked, input bit keep_all);
        for (int i = 0; i < N; i++) begin
            if (acked[i]) begin
                I_Data[i*32 +: 32] = rand_data();
                I_Req[i] = keep_all ? 1'b1 : 1'($urandom_range(0, 1));
            end else if (!keep_all) begin
                if (I_Req[i] && $urandom_range(0, 15) == 0) begin
                    I_Req[i] = 1'b0;
                end else if (!I_Req[i] && $urandom_range(0, 2) == 0) begin
                    I_Data[i*32 +: 32] = rand_data();
                    I_Req[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset();
        I_Req = '1;
        I_Rdy = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            sample();
            n_tests++;
            if (O_Ack !== '0) begin
                n_fail++;
                $display("FAIL reset_ack cyc=%0d ack=%b expected 0000", cyc, O_Ack);
            end
            tick();
        end
        sample();
        n_tests++;
        if ({O_Valid, O_Num, O_Zero, O_ID} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs valid=%b num=%0d zero=%b id=%0d expected all 0",
                     O_Valid, O_Num, O_Zero, O_ID);
        end
        tick();
        reset = 1'b0;
        I_Req = '0;
    endtask

    task automatic test_single_zero();
        I_Req  = 4'b0100;
        I_Data = '0;
        I_Rdy  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sample();
            if (k == 0) begin
                n_tests++;
                if (O_Ack !== 4'b0100) begin
                    n_fail++;
                    $display("FAIL zero_ack ack=%b expected 0100", O_Ack);
                end
            end
            if (k == 2) begin
                n_tests++;
                if ({O_Valid, O_Zero, O_Num, O_ID} !== {1'b1, 1'b1, 5'd0, 2'd2}) begin
                    n_fail++;
                    $display("FAIL zero_result valid=%b zero=%b num=%0d id=%0d expected 1/1/0/2",
                             O_Valid, O_Zero, O_Num, O_ID);
                end
            end
            n_tests++;
            if (O_Ack !== exp_ack || O_Valid !== exp_valid ||
                (exp_valid && {O_Num, O_Zero, O_ID} !== {exp_num, exp_zero, exp_id})) begin
                n_fail++;
                $display("FAIL zero_model cyc=%0d ack=%b/%b valid=%b/%b num=%0d/%0d zero=%b/%b id=%0d/%0d",
                         cyc, O_Ack, exp_ack, O_Valid, exp_valid, O_Num, exp_num, O_Zero, exp_zero, O_ID, exp_id);
            end
            tick();
            I_Req = '0;
        end
    endtask

    task automatic test_req0();
        I_Req          = 4'b0001;
        I_Data[31:0]   = 32'h0001_0000;
        I_Rdy          = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sample();
            if (k == 2) begin
                n_tests++;
                if ({O_Valid, O_Zero, O_Num, O_ID} !== {1'b1, 1'b0, 5'd15, 2'd0}) begin
                    n_fail++;
                    $display("FAIL req0_result valid=%b zero=%b num=%0d id=%0d expected 1/0/15/0",
                             O_Valid, O_Zero, O_Num, O_ID);
                end
            end
            n_tests++;
            if (O_Ack !== exp_ack || O_Valid !== exp_valid ||
                (exp_valid && {O_Num, O_Zero, O_ID} !== {exp_num, exp_zero, exp_id})) begin
                n_fail++;
                $display("FAIL req0_model cyc=%0d ack=%b/%b valid=%b/%b num=%0d/%0d zero=%b/%b id=%0d/%0d",
                         cyc, O_Ack, exp_ack, O_Valid, exp_valid, O_Num, exp_num, O_Zero, exp_zero, O_ID, exp_id);
            end
            tick();
            I_Req = '0;
        end
    endtask

    task automatic test_all_rotate();
        logic [N-1:0] want;
        do_reset();
        I_Rdy = 1'b1;
        I_Req = '1;
        refresh_reqs('1, 1'b1);
        for (int k = 0; k < 14; k++) begin
            sample();
            want = '0;
            want[k % N] = 1'b1;
            n_tests++;
            if (O_Ack !== want || (k >= 2 && (O_Valid !== 1'b1 || O_ID !== IW'((k - 2) % N)))) begin
                n_fail++;
                $display("FAIL rotate_order k=%0d ack=%b expected %b valid=%b id=%0d", k, O_Ack, want, O_Valid, O_ID);
            end
            n_tests++;
            if (O_Ack !== exp_ack || O_Valid !== exp_valid ||
                (exp_valid && {O_Num, O_Zero, O_ID} !== {exp_num, exp_zero, exp_id})) begin
                n_fail++;
                $display("FAIL rotate_model cyc=%0d ack=%b/%b valid=%b/%b num=%0d/%0d zero=%b/%b id=%0d/%0d",
                         cyc, O_Ack, exp_ack, O_Valid, exp_valid, O_Num, exp_num, O_Zero, exp_zero, O_ID, exp_id);
            end
            tick();
            refresh_reqs(exp_ack, 1'b1);
        end
    endtask

    task automatic test_back_to_back_stall();
        int      acks;
        int      drained[$];
        bit      ok;
        do_reset();
        I_Req = '1;
        I_Rdy = 1'b0;
        acks  = 0;
        for (int k = 0; k < 13; k++) begin
            if (k == 5) I_Rdy = 1'b1;
            sample();
            acks += $countones(O_Ack);
            if (k == 4) begin
                n_tests++;
                if (acks != 2 || O_Valid !== 1'b1 || O_ID !== 2'd0) begin
                    n_fail++;
                    $display("FAIL stall_hold acks=%0d valid=%b id=%0d expected 2/1/0", acks, O_Valid, O_ID);
                end
            end
            if (O_Valid === 1'b1 && I_Rdy) drained.push_back(int'(O_ID));
            n_tests++;
            if (O_Ack !== exp_ack || O_Valid !== exp_valid ||
                (exp_valid && {O_Num, O_Zero, O_ID} !== {exp_num, exp_zero, exp_id})) begin
                n_fail++;
                $display("FAIL stall_model cyc=%0d ack=%b/%b valid=%b/%b num=%0d/%0d zero=%b/%b id=%0d/%0d",
                         cyc, O_Ack, exp_ack, O_Valid, exp_valid, O_Num, exp_num, O_Zero, exp_zero, O_ID, exp_id);
            end
            tick();
            refresh_reqs(exp_ack, 1'b1);
        end
        ok = (drained.size() == 8);
        foreach (drained[j]) if (drained[j] != j % N) ok = 1'b0;
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL stall_drain drained=%0d results (first id %0d) expected 8 in order 0,1,2,3,...",
                     drained.size(), (drained.size() > 0) ? drained[0] : -1);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        I_Req = '1;
        I_Rdy = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (k == 3) begin
                reset = 1'b1;
                I_Req = 4'b1110;
            end
            if (k == 4) begin
                reset = 1'b0;
                I_Rdy = 1'b1;
            end
            sample();
            if (k == 3) begin
                n_tests++;
                if (O_Ack !== '0) begin
                    n_fail++;
                    $display("FAIL midreset_ack ack=%b expected 0000", O_Ack);
                end
            end
            if (k == 4) begin
                n_tests++;
                if (O_Valid !== 1'b0 || O_Ack !== 4'b0010) begin
                    n_fail++;
                    $display("FAIL midreset_after valid=%b ack=%b expected 0/0010", O_Valid, O_Ack);
                end
            end
            n_tests++;
            if (O_Ack !== exp_ack || O_Valid !== exp_valid ||
                (exp_valid && {O_Num, O_Zero, O_ID} !== {exp_num, exp_zero, exp_id})) begin
                n_fail++;
                $display("FAIL midreset_model cyc=%0d ack=%b/%b valid=%b/%b num=%0d/%0d zero=%b/%b id=%0d/%0d",
                         cyc, O_Ack, exp_ack, O_Valid, exp_valid, O_Num, exp_num, O_Zero, exp_zero, O_ID, exp_id);
            end
            tick();
            if (k >= 4) I_Req = I_Req & ~exp_ack;
        end
    endtask

    task automatic test_pointer_skip();
        logic [N-1:0] reqs [5] = '{4'b0010, 4'b1010, 4'b0010, 4'b1111, 4'b0000};
        logic [N-1:0] want [5] = '{4'b0010, 4'b1000, 4'b0010, 4'b0100, 4'b0000};
        do_reset();
        I_Rdy = 1'b1;
        for (int k = 0; k < 7; k++) begin
            I_Req = (k < 5) ? reqs[k] : '0;
            sample();
            if (k < 5) begin
                n_tests++;
                if (O_Ack !== want[k]) begin
                    n_fail++;
                    $display("FAIL ptr_grant step=%0d ack=%b expected %b", k, O_Ack, want[k]);
                end
            end
            n_tests++;
            if (O_Ack !== exp_ack || O_Valid !== exp_valid ||
                (exp_valid && {O_Num, O_Zero, O_ID} !== {exp_num, exp_zero, exp_id})) begin
                n_fail++;
                $display("FAIL ptr_model cyc=%0d ack=%b/%b valid=%b/%b num=%0d/%0d zero=%b/%b id=%0d/%0d",
                         cyc, O_Ack, exp_ack, O_Valid, exp_valid, O_Num, exp_num, O_Zero, exp_zero, O_ID, exp_id);
            end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        I_Req = '0;
        for (int k = 0; k < 600; k++) begin
            I_Rdy = ($urandom_range(0, 9) < 7);
            reset = ($urandom_range(0, 99) == 0);
            sample();
            n_tests++;
            if (O_Ack !== exp_ack || O_Valid !== exp_valid ||
                (exp_valid && {O_Num, O_Zero, O_ID} !== {exp_num, exp_zero, exp_id})) begin
                n_fail++;
                $display("FAIL random_model cyc=%0d ack=%b/%b valid=%b/%b num=%0d/%0d zero=%b/%b id=%0d/%0d",
                         cyc, O_Ack, exp_ack, O_Valid, exp_valid, O_Num, exp_num, O_Zero, exp_zero, O_ID, exp_id);
            end
            tick();
            refresh_reqs(exp_ack, 1'b0);
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_zero();
        test_req0();
        test_all_rotate();
        test_back_to_back_stall();
        test_reset_mid();
        test_pointer_skip();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
